// File: rtl/cache_port_arbiter.sv
// Cache port arbiter: shares the single cache request port (p0) among
// NUM_REQ requesters with round-robin grants that stay locked until the
// cache accepts, and routes read responses back to their originator via
// an in-order ID FIFO of outstanding reads.
//
// Handshakes are strict valid/ready: a transfer happens on a cycle where
// both valid and ready are high; a valid source holds valid and its
// payload stable until it sees ready. Ready may depend combinationally
// on valid; valid never depends on ready.
//
// With the FIFO empty p0_drdy_o is 1 (an unexpected response is sunk and
// dropped), so it reads 1 out of reset as well.
// dbg_state_o = {lock, lock_id, rr_ptr, count} for checker binding.
module cache_port_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int WMASK_WIDTH     = 4,
  parameter int NUM_REQ         = 2,
  parameter int MAX_OUTSTANDING = 4,
  localparam int IDW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int PTRW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1,
  localparam int CNTW = $clog2(MAX_OUTSTANDING) + 1,
  localparam int DBGW = 1 + 2 * IDW + CNTW
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             rq_vld_i,
  output logic [NUM_REQ-1:0]             rq_rdy_o,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  rq_addr_i,
  input  logic [NUM_REQ-1:0]             rq_web_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  rq_wdat_i,
  input  logic [NUM_REQ*WMASK_WIDTH-1:0] rq_wmask_i,
  output logic [NUM_REQ-1:0]             rs_vld_o,
  input  logic [NUM_REQ-1:0]             rs_rdy_i,
  output logic [DATA_WIDTH-1:0]          rs_dat_o,
  output logic                           p0_uvld_o,
  input  logic                           p0_urdy_i,
  output logic [ADDR_WIDTH-1:0]          p0_addr_o,
  output logic                           p0_web_o,
  output logic [DATA_WIDTH-1:0]          p0_wdat_o,
  output logic [WMASK_WIDTH-1:0]         p0_wmask_o,
  input  logic                           p0_dvld_i,
  output logic                           p0_drdy_o,
  input  logic [DATA_WIDTH-1:0]          p0_ddat_i,
  output logic                           busy_o,
  output logic [DBGW-1:0]                dbg_state_o
);

  // Grant FSM state: lock flag, locked requester, round-robin pointer.
  logic           lock_q, lock_d;
  logic [IDW-1:0] lock_id_q, lock_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  // ID FIFO of outstanding reads.
  logic [IDW-1:0]  id_mem [MAX_OUTSTANDING];
  logic [PTRW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0] count_q;

  logic           cand_found;
  logic [IDW-1:0] cand_id;
  int             scan_idx;
  logic [IDW-1:0] sel;
  logic           sel_vld;
  logic           sel_web;
  logic           fifo_full;
  logic           fifo_empty;
  logic           read_blocked;
  logic           accept;
  logic           push;
  logic           pop;
  logic [IDW-1:0] head_id;

  assign fifo_full  = (count_q == CNTW'(MAX_OUTSTANDING));
  assign fifo_empty = (count_q == '0);
  assign head_id    = id_mem[rd_ptr_q];

  // Round-robin candidate: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    cand_found = 1'b0;
    cand_id    = '0;
    scan_idx   = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = (int'(rr_ptr_q) + i) % NUM_REQ;
      if (!cand_found && rq_vld_i[scan_idx]) begin
        cand_found = 1'b1;
        cand_id    = IDW'(scan_idx);
      end
    end
  end

  // Source selection: a locked grant overrides arbitration; reads stall on a full FIFO.
  always_comb begin
    sel          = lock_q ? lock_id_q : cand_id;
    sel_vld      = lock_q ? rq_vld_i[lock_id_q] : cand_found;
    sel_web      = rq_web_i[sel];
    read_blocked = sel_vld && sel_web && fifo_full;
    accept       = sel_vld && !read_blocked && p0_urdy_i;
    push         = accept && sel_web;
    pop          = p0_dvld_i && !fifo_empty && rs_rdy_i[head_id];
  end

  // Grant state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock_q    <= 1'b0;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      rr_ptr_q  <= rr_ptr_d;
    end
  end

  // Grant next state: accept releases the lock and rotates priority; a stall locks.
  always_comb begin
    lock_d    = lock_q;
    lock_id_d = lock_id_q;
    rr_ptr_d  = rr_ptr_q;
    if (accept) begin
      lock_d   = 1'b0;
      rr_ptr_d = IDW'((int'(sel) + 1) % NUM_REQ);
    end else if (sel_vld && !read_blocked) begin
      lock_d    = 1'b1;
      lock_id_d = sel;
    end
  end

  // Outputs: muxed request fields, per-requester ready, response routing.
  always_comb begin
    p0_uvld_o  = sel_vld && !read_blocked;
    p0_addr_o  = '0;
    p0_web_o   = 1'b1;
    p0_wdat_o  = '0;
    p0_wmask_o = '0;
    if (sel_vld) begin
      p0_addr_o  = rq_addr_i[int'(sel) * ADDR_WIDTH +: ADDR_WIDTH];
      p0_web_o   = sel_web;
      p0_wdat_o  = rq_wdat_i[int'(sel) * DATA_WIDTH +: DATA_WIDTH];
      p0_wmask_o = rq_wmask_i[int'(sel) * WMASK_WIDTH +: WMASK_WIDTH];
    end
    rq_rdy_o = '0;
    if (sel_vld && !read_blocked) begin
      rq_rdy_o[sel] = p0_urdy_i;
    end
    rs_vld_o = '0;
    if (!fifo_empty) begin
      rs_vld_o[head_id] = p0_dvld_i;
    end
    p0_drdy_o = fifo_empty ? 1'b1 : rs_rdy_i[head_id];
    rs_dat_o  = p0_ddat_i;
  end

  // ID FIFO: push the granted ID on an accepted read, pop on a response handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int k = 0; k < MAX_OUTSTANDING; k++) begin
        id_mem[k] <= '0;
      end
    end else begin
      if (push) begin
        id_mem[wr_ptr_q] <= sel;
        wr_ptr_q         <= wr_ptr_q + PTRW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTRW'(1);
      end
      count_q <= count_q + CNTW'(push) - CNTW'(pop);
    end
  end

  assign busy_o      = !fifo_empty;
  assign dbg_state_o = {lock_q, lock_id_q, rr_ptr_q, count_q};

endmodule
